neuron_potential_accumulator: RTL



---
 rtl/neuron_potential_accumulator.sv | 139 +++++++++++++
 1 files changed

// File: rtl/neuron_potential_accumulator.sv
// neuron_potential_accumulator: FP32 integrate-and-fire stage; NEURON_REFRACTORY_EN adds a refractory period after each spike.
module neuron_potential_accumulator #(
  parameter int REFRACTORY_STEPS = 2,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   timestep_start,
  input  logic [31:0]            decayed_potential,
  input  logic                   weight_valid,
  input  logic [31:0]            weight,
  output logic                   weight_ready,
  input  logic                   timestep_end,
  input  logic [31:0]            threshold,
  input  logic [31:0]            reset_potential,
  output logic [31:0]            new_potential,
  output logic                   potential_valid,
  output logic                   spike,
  output logic [COUNT_WIDTH-1:0] weight_count,
  output logic                   add_error,
  output logic                   seq_error
);
  typedef enum logic [1:0] {IDLE, ACCUM, CHECK, EMIT} state_t;
  // Round-to-nearest-even FP32 add; subnormals flush to zero. Returns {exception, sum}.
  function automatic logic [32:0] addition_subtraction(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] l, s;
    logic [23:0] ml, ms;
    logic [7:0]  d;
    logic [50:0] big, sml, sum;
    logic [49:0] nrm;
    logic [30:0] r;
    logic [5:0]  p;
    logic        rnd, exc;
    int          e;
    exc = (&a[30:23]) | (&b[30:23]);
    {l, s} = (a[30:0] >= b[30:0]) ? {a, b} : {b, a};
    ml = (l[30:23] == 8'd0) ? 24'd0 : {1'b1, l[22:0]};
    ms = (s[30:23] == 8'd0) ? 24'd0 : {1'b1, s[22:0]};
    d = l[30:23] - s[30:23];
    big = {1'b0, ml, 26'd0};
    // 26 spare bits keep alignment exact; beyond that the small operand only matters as sticky
    sml = (d > 8'd26) ? {50'd0, |ms} : ({1'b0, ms, 26'd0} >> d);
    sum = (l[31] == s[31]) ? big + sml : big - sml;
    p = 6'd0;
    for (int i = 0; i < 51; i++)
      if (sum[i]) p = i[5:0];
    nrm = sum[49:0] << (6'd50 - p);
    rnd = nrm[26] & (nrm[27] | (|nrm[25:0]));
    e = int'(l[30:23]) + int'(p) - 49;
    r = {e[7:0], nrm[49:27]} + {30'd0, rnd};
    if (sum == '0 || e <= 0)
      return {exc, (sum == '0) ? 1'b0 : l[31], 31'd0};
    if (e >= 255 || (&r[30:23]))
      return {1'b1, l[31], 31'd0};
    return {exc, l[31], r};
  endfunction
  function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
    return (a[30:0] == 31'd0 && b[30:0] == 31'd0) ? 1'b1 :
           (a[31] != b[31]) ? ~a[31] :
           a[31] ? (a[30:0] <= b[30:0]) : (a[30:0] >= b[30:0]);
  endfunction
  state_t                 state;
  logic [31:0]            potential;
  logic [COUNT_WIDTH-1:0] cnt;
  logic                   fire;
  logic                   refr_act;
  logic [32:0]            add_res;
  logic                   hs;
  assign add_res = addition_subtraction(potential, weight);
  assign hs = weight_valid & weight_ready;
`ifdef NEURON_REFRACTORY_EN
  localparam int RW = $clog2(REFRACTORY_STEPS + 2);
  logic [RW-1:0] refr;
  assign refr_act = refr != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      refr <= '0;
    else if (state == EMIT)
      refr <= refr_act ? refr - RW'(1) : fire ? RW'(REFRACTORY_STEPS) : refr;
`else
  localparam int unused_refr = REFRACTORY_STEPS;
  assign refr_act = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      potential <= '0;
      cnt <= '0;
      fire <= 1'b0;
      weight_ready <= 1'b0;
      new_potential <= '0;
      potential_valid <= 1'b0;
      spike <= 1'b0;
      weight_count <= '0;
      add_error <= 1'b0;
      seq_error <= 1'b0;
    end else begin
      potential_valid <= 1'b0;
      spike <= 1'b0;
      if ((timestep_start && state != IDLE) || (timestep_end && state != ACCUM))
        seq_error <= 1'b1;
      case (state)
        IDLE:
          if (timestep_start) begin
            potential <= decayed_potential;
            cnt <= '0;
            weight_ready <= 1'b1;
            state <= ACCUM;
          end
        ACCUM: begin
          if (hs) begin
            cnt <= (&cnt) ? cnt : cnt + COUNT_WIDTH'(1);
            if (!refr_act) begin
              if (add_res[32])
                add_error <= 1'b1;
              else
                potential <= add_res[31:0];
            end
          end
          if (timestep_end) begin
            weight_ready <= 1'b0;
            state <= CHECK;
          end
        end
        CHECK: begin
          fire <= ~refr_act & fp_ge(potential, threshold);
          state <= EMIT;
        end
        EMIT: begin
          new_potential <= (fire || refr_act) ? reset_potential : potential;
          potential_valid <= 1'b1;
          spike <= fire;
          weight_count <= cnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
